// File: rtl/puf_ro_window_counter_if.sv
// Bus bundle for the PUF ring-oscillator window counter.
// The measurement side (timer plus oscillator taps) drives ctrl/clear/ro_*.
// The counter reports counts, response bits and status back on the same bundle.
interface puf_ro_window_counter_if #(
   parameter int CNT_W  = 16,
   parameter int RESP_W = 8
);
   logic              ctrl;
   logic              clear;
   logic              ro_a;
   logic              ro_b;
   logic [CNT_W-1:0]  cnt_a;
   logic [CNT_W-1:0]  cnt_b;
   logic              bit_out;
   logic              bit_tie;
   logic              bit_valid;
   logic [RESP_W-1:0] resp;
   logic              resp_valid;
   logic              busy;

   // Stimulus side: the window timer, the controller and the oscillators
   modport master (
      output ctrl, clear, ro_a, ro_b,
      input  cnt_a, cnt_b, bit_out, bit_tie, bit_valid, resp, resp_valid, busy
   );

   // Counter side
   modport slave (
      input  ctrl, clear, ro_a, ro_b,
      output cnt_a, cnt_b, bit_out, bit_tie, bit_valid, resp, resp_valid, busy
   );
endinterface

// File: rtl/puf_ro_window_counter.sv
// PUF ring-oscillator window counter.
// Counts synchronized rising edges of two async oscillator taps while the
// timer window (ctrl) is open, drains the synchronizers after close, then
// compares the counts into one response bit and shifts it into a word.

// One oscillator tap: synchronizer chain, history flop, rising-edge detect
// and a saturating edge counter controlled by the window FSM.
module puf_ro_tap_counter #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ro,
   input  logic             cnt_clr,
   input  logic             cnt_en,
   output logic [CNT_W-1:0] cnt
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   rise;

   // Shift the tap through the synchronizer, detect a rise, count it
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], ro};
      hist_d = sync_q[SYNC_STAGES-1];
      rise   = sync_q[SYNC_STAGES-1] & ~hist_q;
      cnt_d  = cnt_q;
      if (cnt_clr)
         cnt_d = '0;
      else if (cnt_en && rise && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   // Synchronizer, history and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
         cnt_q  <= cnt_d;
      end
   end

   assign cnt = cnt_q;
endmodule

module puf_ro_window_counter #(
   parameter int CNT_W       = 16,
   parameter int RESP_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   puf_ro_window_counter_if.slave bus
);
   localparam int DW = $clog2(SYNC_STAGES + 1);
   localparam int IW = $clog2(RESP_W + 1);

   typedef enum logic [1:0] {IDLE, COUNT, DRAIN, CMP} state_t;

   state_t                 state_q, state_d;
   logic [DW-1:0]          drain_q, drain_d;
   logic                   pend_q, pend_d;
   logic                   ctrl_dly_q, ctrl_dly_d;
   logic [CNT_W-1:0]       cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0]       cnt_b_q, cnt_b_d;
   logic                   bit_out_q, bit_out_d;
   logic                   bit_tie_q, bit_tie_d;
   logic                   bit_valid_q, bit_valid_d;
   logic [RESP_W-1:0]      resp_q, resp_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic                   rv_q, rv_d;

   logic                   start;
   logic                   cnt_clr, cnt_en;
   logic                   a_gt_b, a_eq_b;
   logic [1:0]             ro_vec;
   logic [1:0][CNT_W-1:0]  tap_cnt;

   assign ro_vec = {bus.ro_b, bus.ro_a};

   // Tap 0 is oscillator A, tap 1 is oscillator B
   for (genvar g = 0; g < 2; g++) begin : g_tap
      puf_ro_tap_counter #(
         .CNT_W       (CNT_W),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_tap (
         .clk     (clk),
         .rst     (rst),
         .ro      (ro_vec[g]),
         .cnt_clr (cnt_clr),
         .cnt_en  (cnt_en),
         .cnt     (tap_cnt[g])
      );
   end

   assign start  = bus.ctrl & ~ctrl_dly_q;
   assign a_gt_b = tap_cnt[0] > tap_cnt[1];
   assign a_eq_b = tap_cnt[0] == tap_cnt[1];

   // Window FSM, result capture and response accumulation
   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      pend_d      = pend_q;
      ctrl_dly_d  = bus.ctrl;
      cnt_a_d     = cnt_a_q;
      cnt_b_d     = cnt_b_q;
      bit_out_d   = bit_out_q;
      bit_tie_d   = bit_tie_q;
      bit_valid_d = 1'b0;
      resp_d      = resp_q;
      idx_d       = idx_q;
      rv_d        = rv_q;
      cnt_clr     = 1'b0;
      cnt_en      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start || pend_q) begin
               cnt_clr = 1'b1;
               pend_d  = 1'b0;
               state_d = COUNT;
            end
         end
         COUNT: begin
            // A rising ctrl cannot occur here; the window is already open
            cnt_en = 1'b1;
            if (!bus.ctrl) begin
               drain_d = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Keep counting edges still travelling through the synchronizers
            cnt_en = 1'b1;
            if (start)
               pend_d = 1'b1;
            if (drain_q == DW'(SYNC_STAGES))
               state_d = CMP;
            else
               drain_d = drain_q + DW'(1);
         end
         CMP: begin
            if (start)
               pend_d = 1'b1;
            cnt_a_d     = tap_cnt[0];
            cnt_b_d     = tap_cnt[1];
            bit_out_d   = a_gt_b;
            bit_tie_d   = a_eq_b;
            bit_valid_d = 1'b1;
            // Once the word is full it is frozen until clear
            if (!rv_q) begin
               resp_d = {resp_q[RESP_W-2:0], a_gt_b};
               idx_d  = idx_q + IW'(1);
               if (idx_q + IW'(1) == IW'(RESP_W))
                  rv_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Abort wins over everything, including a same-cycle window start;
      // the last reported result stays visible
      if (bus.clear) begin
         state_d     = IDLE;
         drain_d     = '0;
         pend_d      = 1'b0;
         cnt_clr     = 1'b1;
         cnt_en      = 1'b0;
         cnt_a_d     = cnt_a_q;
         cnt_b_d     = cnt_b_q;
         bit_out_d   = bit_out_q;
         bit_tie_d   = bit_tie_q;
         bit_valid_d = 1'b0;
         resp_d      = '0;
         idx_d       = '0;
         rv_d        = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         drain_q     <= '0;
         pend_q      <= 1'b0;
         ctrl_dly_q  <= 1'b0;
         cnt_a_q     <= '0;
         cnt_b_q     <= '0;
         bit_out_q   <= 1'b0;
         bit_tie_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         resp_q      <= '0;
         idx_q       <= '0;
         rv_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         pend_q      <= pend_d;
         ctrl_dly_q  <= ctrl_dly_d;
         cnt_a_q     <= cnt_a_d;
         cnt_b_q     <= cnt_b_d;
         bit_out_q   <= bit_out_d;
         bit_tie_q   <= bit_tie_d;
         bit_valid_q <= bit_valid_d;
         resp_q      <= resp_d;
         idx_q       <= idx_d;
         rv_q        <= rv_d;
      end
   end

   assign bus.cnt_a      = cnt_a_q;
   assign bus.cnt_b      = cnt_b_q;
   assign bus.bit_out    = bit_out_q;
   assign bus.bit_tie    = bit_tie_q;
   assign bus.bit_valid  = bit_valid_q;
   assign bus.resp       = resp_q;
   assign bus.resp_valid = rv_q;
   assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_puf_ro_window_counter.sv
// Directed bench for puf_ro_window_counter: a default-width instance and a
// 4-bit-counter instance see identical stimulus.
module tb_puf_ro_window_counter;
   logic clk = 1'b0;
   logic rst, ctrl, clear, ro_a, ro_b;
   int   checks = 0;
   int   errors = 0;
   logic s_bv, s_busy;

   always #5 clk = ~clk;

   puf_ro_window_counter_if #(.CNT_W(16), .RESP_W(8)) bus  ();
   puf_ro_window_counter_if #(.CNT_W(4),  .RESP_W(8)) bus4 ();

   assign bus.ctrl   = ctrl;
   assign bus.clear  = clear;
   assign bus.ro_a   = ro_a;
   assign bus.ro_b   = ro_b;
   assign bus4.ctrl  = ctrl;
   assign bus4.clear = clear;
   assign bus4.ro_a  = ro_a;
   assign bus4.ro_b  = ro_b;

   puf_ro_window_counter #(.CNT_W(16), .RESP_W(8), .SYNC_STAGES(2)) u_dut (
      .clk (clk), .rst (rst), .bus (bus)
   );
   puf_ro_window_counter #(.CNT_W(4), .RESP_W(8), .SYNC_STAGES(2)) u_dut4 (
      .clk (clk), .rst (rst), .bus (bus4)
   );

   // Square wave: n rising edges of period p, first rise at k = 0
   function automatic logic tap(input int k, input int p, input int n);
      return (k >= 0) && (k / p < n) && (k % p < p / 2);
   endfunction

   // Sample outputs of the last posedge, then drive the next cycle's inputs
   task automatic step(input logic c, input logic a, input logic b, input logic cl);
      @(negedge clk);
      s_bv   = bus.bit_valid;
      s_busy = bus.busy;
      ctrl   = c;
      ro_a   = a;
      ro_b   = b;
      clear  = cl;
   endtask

   // ctrl high for len cycles, taps start one cycle in, then 8 idle cycles
   task automatic run_win(input int len, input int pa, input int na, input int pb, input int nb,
                          output int bv_off, output int bv_n,
                          output logic b_start, output logic b_cmp, output logic b_after);
      bv_off = -1; bv_n = 0; b_start = 1'b0; b_cmp = 1'b0; b_after = 1'b1;
      for (int i = 0; i < len + 8; i++) begin
         step(i < len, tap(i - 1, pa, na), tap(i - 1, pb, nb), 1'b0);
         if (s_bv === 1'b1) begin bv_n++; bv_off = i; end
         if (i == 1)       b_start = s_busy;
         if (i == len + 4) b_cmp   = s_busy;
         if (i == len + 5) b_after = s_busy;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; ctrl = 1'b0; clear = 1'b0; ro_a = 1'b0; ro_b = 1'b0;
      for (int i = 0; i < 3; i++) step(i[0], ~i[0], i[0], 1'b0);
      @(negedge clk);
      checks++; if (bus.cnt_a !== 16'd0 || bus.cnt_b !== 16'd0) begin errors++;
         $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.cnt_a, bus.cnt_b); end
      checks++; if ({bus.bit_out, bus.bit_tie, bus.bit_valid} !== 3'b000) begin errors++;
         $display("FAIL reset_bits: got %b want 000", {bus.bit_out, bus.bit_tie, bus.bit_valid}); end
      checks++; if (bus.resp !== 8'd0 || bus.resp_valid !== 1'b0) begin errors++;
         $display("FAIL reset_resp: got %h/%b want 00/0", bus.resp, bus.resp_valid); end
      checks++; if (bus.busy !== 1'b0 || bus4.busy !== 1'b0) begin errors++;
         $display("FAIL reset_busy: got %b/%b want 0/0", bus.busy, bus4.busy); end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_single();
      int bv_off, bv_n; logic bs, bc, ba;
      run_win(50, 4, 12, 6, 8, bv_off, bv_n, bs, bc, ba);
      checks++; if (bus.cnt_a !== 16'd12 || bus.cnt_b !== 16'd8) begin errors++;
         $display("FAIL single_cnt: got %0d/%0d want 12/8", bus.cnt_a, bus.cnt_b); end
      checks++; if (bus.bit_out !== 1'b1 || bus.bit_tie !== 1'b0) begin errors++;
         $display("FAIL single_bit: got out=%b tie=%b want 1/0", bus.bit_out, bus.bit_tie); end
      checks++; if (bv_n !== 1 || bv_off !== 55) begin errors++;
         $display("FAIL single_bv: got n=%0d at %0d want 1 at 55", bv_n, bv_off); end
      checks++; if ({bs, bc, ba} !== 3'b110) begin errors++;
         $display("FAIL single_busy: got start/cmp/after=%b want 110", {bs, bc, ba}); end
      checks++; if (bus.resp !== 8'h01 || bus.resp_valid !== 1'b0) begin errors++;
         $display("FAIL single_resp: got %h/%b want 01/0", bus.resp, bus.resp_valid); end
   endtask

   task automatic test_tie();
      int bv_off, bv_n; logic bs, bc, ba;
      run_win(50, 4, 10, 4, 10, bv_off, bv_n, bs, bc, ba);
      checks++; if (bus.cnt_a !== 16'd10 || bus.cnt_b !== 16'd10) begin errors++;
         $display("FAIL tie_cnt: got %0d/%0d want 10/10", bus.cnt_a, bus.cnt_b); end
      checks++; if (bus.bit_out !== 1'b0 || bus.bit_tie !== 1'b1) begin errors++;
         $display("FAIL tie_bit: got out=%b tie=%b want 0/1", bus.bit_out, bus.bit_tie); end
      checks++; if (bus.resp !== 8'h02 || bv_n !== 1) begin errors++;
         $display("FAIL tie_resp: got %h bv=%0d want 02 bv=1", bus.resp, bv_n); end
   endtask

   task automatic test_saturation();
      int bv_off, bv_n; logic bs, bc, ba;
      run_win(84, 4, 20, 4, 5, bv_off, bv_n, bs, bc, ba);
      checks++; if (bus4.cnt_a !== 4'd15 || bus4.cnt_b !== 4'd5) begin errors++;
         $display("FAIL sat_cnt: got %0d/%0d want 15/5", bus4.cnt_a, bus4.cnt_b); end
      checks++; if (bus4.bit_out !== 1'b1 || bus4.bit_tie !== 1'b0) begin errors++;
         $display("FAIL sat_bit: got out=%b tie=%b want 1/0", bus4.bit_out, bus4.bit_tie); end
      checks++; if (bus.cnt_a !== 16'd20 || bus.cnt_b !== 16'd5) begin errors++;
         $display("FAIL wide_cnt: got %0d/%0d want 20/5", bus.cnt_a, bus.cnt_b); end
   endtask

   task automatic test_full_word();
      int bv_off, bv_n, total; logic bs, bc, ba;
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (bus.resp !== 8'h00 || bus.resp_valid !== 1'b0) begin errors++;
         $display("FAIL word_preclear: got %h/%b want 00/0", bus.resp, bus.resp_valid); end
      total = 0;
      for (int w = 0; w < 8; w++) begin
         if (w % 2 == 0) run_win(30, 4, 6, 4, 3, bv_off, bv_n, bs, bc, ba);
         else            run_win(30, 4, 3, 4, 6, bv_off, bv_n, bs, bc, ba);
         total += bv_n;
         if (w == 6) begin
            checks++; if (bus.resp_valid !== 1'b0) begin errors++;
               $display("FAIL word_early_valid: got %b want 0", bus.resp_valid); end
         end
      end
      checks++; if (bus.resp !== 8'hAA || bus.resp_valid !== 1'b1 || total !== 8) begin errors++;
         $display("FAIL word_full: got %h/%b bv=%0d want aa/1 bv=8", bus.resp, bus.resp_valid, total); end
      run_win(30, 4, 6, 4, 3, bv_off, bv_n, bs, bc, ba);
      checks++; if (bv_n !== 1 || bus.resp !== 8'hAA || bus.resp_valid !== 1'b1) begin errors++;
         $display("FAIL word_hold: got bv=%0d %h/%b want 1 aa/1", bv_n, bus.resp, bus.resp_valid); end
      checks++; if (bus.cnt_a !== 16'd6 || bus.cnt_b !== 16'd3) begin errors++;
         $display("FAIL word_ninth_cnt: got %0d/%0d want 6/3", bus.cnt_a, bus.cnt_b); end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (bus.resp !== 8'h00 || bus.resp_valid !== 1'b0) begin errors++;
         $display("FAIL word_clear: got %h/%b want 00/0", bus.resp, bus.resp_valid); end
   endtask

   task automatic test_clear_mid();
      int bvn = 0;
      for (int i = 0; i < 40; i++) begin
         step(i < 20, tap(i - 1, 4, 8), tap(i - 1, 4, 2), i == 10);
         if (s_bv === 1'b1) bvn++;
         if (i == 5) begin
            checks++; if (s_busy !== 1'b1) begin errors++;
               $display("FAIL clr_busy_before: got %b want 1", s_busy); end
         end
         if (i == 11) begin
            checks++; if (s_busy !== 1'b0) begin errors++;
               $display("FAIL clr_idle: got busy=%b want 0", s_busy); end
         end
      end
      checks++; if (bvn !== 0) begin errors++;
         $display("FAIL clr_no_bv: got %0d pulses want 0", bvn); end
      checks++; if (bus.cnt_a !== 16'd6 || bus.cnt_b !== 16'd3 || bus.bit_out !== 1'b1) begin errors++;
         $display("FAIL clr_hold: got %0d/%0d out=%b want 6/3 out=1", bus.cnt_a, bus.cnt_b, bus.bit_out); end
   endtask

   task automatic test_back_to_back();
      int bvn = 0, first = -1, last = -1;
      for (int i = 0; i < 80; i++) begin
         step((i < 30) || (i >= 31 && i < 70),
              tap(i - 1, 4, 5) | tap(i - 40, 4, 3),
              tap(i - 1, 4, 2) | tap(i - 40, 4, 7), 1'b0);
         if (s_bv === 1'b1) begin bvn++; if (first < 0) first = i; last = i; end
         if (i == 36) begin
            checks++; if (bus.cnt_a !== 16'd5 || bus.cnt_b !== 16'd2 || bus.bit_out !== 1'b1) begin errors++;
               $display("FAIL b2b_first: got %0d/%0d out=%b want 5/2 out=1", bus.cnt_a, bus.cnt_b, bus.bit_out); end
            checks++; if (s_busy !== 1'b1) begin errors++;
               $display("FAIL b2b_pending: got busy=%b want 1", s_busy); end
         end
      end
      checks++; if (bvn !== 2 || first !== 35 || last !== 75) begin errors++;
         $display("FAIL b2b_bv: got n=%0d at %0d,%0d want 2 at 35,75", bvn, first, last); end
      checks++; if (bus.cnt_a !== 16'd3 || bus.cnt_b !== 16'd7 || bus.bit_out !== 1'b0 || bus.bit_tie !== 1'b0) begin errors++;
         $display("FAIL b2b_second: got %0d/%0d out=%b tie=%b want 3/7 0/0",
                  bus.cnt_a, bus.cnt_b, bus.bit_out, bus.bit_tie); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_saturation();
      test_full_word();
      test_clear_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
